adder_6_vector_checker: RTL

Synthesizable stimulus generator and self-checker sitting directly upstream and downstream of the pre-configured adder_6 fabric wrapper. It drives every `a`, `b` and `cin` combination into the fabric's benchmark inputs. After a fixed settle time it samples `out_sum` and `out_cout` and compares them against a golden WIDTH-bit adder. It then reports pass/fail, the mismatch count and the first failing vector, for post-configuration silicon or emulation checks.

---
 rtl/adder_chk_pkg.sv | 18 +
 rtl/adder_chk_vec_gen.sv | 56 +++++
 rtl/adder_6_vector_checker.sv | 119 +++++++++++
 3 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder_6 fabric vector checker.
package adder_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } chk_state_e;

    // x^13 + x^4 + x^3 + x + 1, low-order terms for a left-shifting Galois LFSR
    localparam logic [12:0] LFSR13_TAPS = 13'h001B;

    function automatic int VEC_W(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/adder_chk_vec_gen.sv
// Vector index source for the checker: binary up-counter by default, or a
// maximal-length Galois LFSR seeded to 1 when ADDER_CHK_LFSR_EN is defined.
module adder_chk_vec_gen
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic                    i_advance,
    output logic [VEC_W(WIDTH)-1:0] o_idx,
    output logic                    o_last
);

    localparam int VW = VEC_W(WIDTH);

    logic [VW-1:0] r_idx;
    logic [VW-1:0] w_next;

`ifdef ADDER_CHK_LFSR_EN
    localparam logic [VW-1:0] SEED = VW'(1);

    if (VW != 13) begin : g_bad_width
        $error("adder_chk_vec_gen: LFSR taps are only defined for WIDTH=6");
    end

    always_comb begin
        w_next = {r_idx[VW-2:0], 1'b0};
        if (r_idx[VW-1]) begin
            w_next = w_next ^ VW'(LFSR13_TAPS);
        end
    end

    // The run closes on the state whose successor is the seed again.
    assign o_last = (w_next == SEED);
`else
    localparam logic [VW-1:0] SEED = '0;

    assign w_next = r_idx + VW'(1);
    assign o_last = &r_idx;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_idx <= SEED;
        end else if (i_advance) begin
            r_idx <= w_next;
        end
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/adder_6_vector_checker.sv
// Stimulus generator and self-checker around the adder_6 fabric wrapper.
// Optional build macro ADDER_CHK_LFSR_EN selects LFSR vector ordering.
module adder_6_vector_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH         = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [WIDTH-1:0]        a_out,
    output logic [WIDTH-1:0]        b_out,
    output logic                    cin_out,
    input  logic [WIDTH-1:0]        sum_in,
    input  logic                    cout_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic [VEC_W(WIDTH)-1:0] first_err_vec,
    output logic [VEC_W(WIDTH)-1:0] vec_count
);

    localparam int VW   = VEC_W(WIDTH);
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);

    chk_state_e           r_state;
    logic [SC_W-1:0]      r_settle_cnt;
    logic [VW-1:0]        w_idx;
    logic                 w_last;
    logic                 w_start_ok;
    logic                 w_advance;
    logic [WIDTH:0]       w_golden;
    logic                 w_mismatch;
    logic [ERR_CNT_W-1:0] w_err_next;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_advance  = (r_state == ST_CHECK) && !w_last;

    adder_chk_vec_gen #(
        .WIDTH (WIDTH)
    ) u_vec_gen (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_start_ok),
        .i_advance (w_advance),
        .o_idx     (w_idx),
        .o_last    (w_last)
    );

    assign a_out   = w_idx[WIDTH-1:0];
    assign b_out   = w_idx[2*WIDTH-1:WIDTH];
    assign cin_out = w_idx[2*WIDTH];

    // Golden reference is taken from the registered stimulus, not the fabric.
    assign w_golden   = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, cin_out};
    assign w_mismatch = ({cout_in, sum_in} != w_golden);
    assign w_err_next = w_mismatch ? sat_inc(err_count) : err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_settle_cnt  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
            vec_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_SETTLE;
                        r_settle_cnt  <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_vec <= '0;
                        vec_count     <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SC_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SC_W'(1);
                    end
                end
                ST_CHECK: begin
                    err_count <= w_err_next;
                    if (w_mismatch && (err_count == '0)) begin
                        first_err_vec <= w_idx;
                    end
                    vec_count <= vec_count + VW'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                    end else begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
